vid_mem_resp: RTL and testbench

Bus responder (target) for the video bus: accepts single and burst read/write requests on the `selin`/`cmdin`/`lenin`/`addrdatain` request channel and returns read data on `cmdout`/`lenout`/`addrdataout`. It is the memory-side end of the link the video controller masters. It backs the frame-buffer fetches, plus register/test accesses, with a word-addressed synchronous RAM.

---
 rtl/vid_bus_pkg.sv | 33 +++
 rtl/vid_mem_array.sv | 32 +++
 rtl/vid_mem_resp.sv | 129 ++++++++++++
 tb/tb_vid_mem_resp.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_bus_pkg.sv
// Shared definitions for the video bus: command and burst-length encodings.
// Used by both the memory responder and the video controller.
package vid_bus_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'b000,
    CMD_WRITE = 3'b010,
    CMD_WDATA = 3'b011,
    CMD_READ  = 3'b100,
    CMD_RDATA = 3'b101
  } cmd_t;

  typedef enum logic [1:0] {
    LEN_1 = 2'b00,
    LEN_2 = 2'b01,
    LEN_4 = 2'b10,
    LEN_8 = 2'b11
  } len_t;

  // Beat counters must hold up to 8.
  localparam int BEAT_W = 4;

  // Convert a burst-length code into the number of beats.
  function automatic logic [BEAT_W-1:0] len2beats(input len_t len);
    case (len)
      LEN_1:   return 4'd1;
      LEN_2:   return 4'd2;
      LEN_4:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/vid_mem_array.sv
// Single-port synchronous word RAM with a registered read port.
// The read register returns to zero on cycles without a read, so it can
// drive the bus data output directly.
module vid_mem_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Storage write port.
  // NOTE: the array has no reset so it maps onto a RAM macro; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Registered read port, zero when not reading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/vid_mem_resp.sv
// Video bus target: accepts single/burst reads and writes and serves them
// from a word-addressed synchronous RAM. Read data leaves straight from the
// RAM read register, so the RD state presents the address one cycle ahead.
module vid_mem_resp
  import vid_bus_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  output logic        ackout,
  output logic        busy,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RWAIT,
    ST_RD
  } resp_st_t;

  resp_st_t          state;
  logic [AW-1:0]     idx;
  logic [BEAT_W-1:0] cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [1:0]        len_q;

  cmd_t          cmd;
  logic [AW-1:0] req_idx;
  logic          ram_we;
  logic          ram_re;

  // Byte-offset bits and index bits above DEPTH are deliberately ignored.
  wire unused_addr_bits = &{addrdatain[31:AW+2], addrdatain[1:0]};

  assign cmd     = cmd_t'(cmdin);
  assign req_idx = addrdatain[AW+1:2];
  assign ram_we  = (state == ST_WR) && selin && (cmd == CMD_WDATA);
  assign ram_re  = (state == ST_RD);

  vid_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx),
    .wdata (addrdatain),
    .rdata (addrdataout)
  );

  // Request FSM with registered handshake and read-beat qualifiers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      lat_cnt <= '0;
      len_q   <= '0;
      ackout  <= 1'b0;
      busy    <= 1'b0;
      cmdout  <= '0;
      lenout  <= '0;
    end else begin
      ackout <= 1'b0;
      cmdout <= CMD_IDLE;
      lenout <= '0;
      case (state)
        ST_IDLE: begin
          if (selin && cmd == CMD_WRITE) begin
            idx    <= req_idx;
            cnt    <= len2beats(len_t'(lenin));
            ackout <= 1'b1;
            busy   <= 1'b1;
            state  <= ST_WR;
          end else if (selin && cmd == CMD_READ) begin
            idx     <= req_idx;
            cnt     <= len2beats(len_t'(lenin));
            len_q   <= lenin;
            lat_cnt <= LAT_W'(RD_LAT - 1);
            ackout  <= 1'b1;
            busy    <= 1'b1;
            state   <= (RD_LAT > 1) ? ST_RWAIT : ST_RD;
          end
        end
        ST_WR: begin
          if (ram_we) begin
            idx <= idx + AW'(1);
            cnt <= cnt - BEAT_W'(1);
            if (cnt == BEAT_W'(1)) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        ST_RWAIT: begin
          if (lat_cnt <= LAT_W'(1)) state <= ST_RD;
          else                      lat_cnt <= lat_cnt - LAT_W'(1);
        end
        ST_RD: begin
          cmdout <= CMD_RDATA;
          lenout <= len_q;
          idx    <= idx + AW'(1);
          cnt    <= cnt - BEAT_W'(1);
          if (cnt == BEAT_W'(1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_mem_resp.sv
// Directed testbench for vid_mem_resp: reset, single access, wrapping burst,
// write stall, busy rejection and reset in the middle of a write burst.
module tb_vid_mem_resp;
  import vid_bus_pkg::*;

  localparam int DEPTH  = 4096;
  localparam int RD_LAT = 2;

  typedef logic [31:0] word_arr_t [8];
  typedef logic [1:0]  len_arr_t  [8];

  logic        clk = 1'b0;
  logic        reset;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic        ackout;
  logic        busy;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;

  int total = 0;
  int bad   = 0;

  vid_mem_resp #(
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .selin       (selin),
    .cmdin       (cmdin),
    .lenin       (lenin),
    .addrdatain  (addrdatain),
    .ackout      (ackout),
    .busy        (busy),
    .cmdout      (cmdout),
    .lenout      (lenout),
    .addrdataout (addrdataout)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are stable when this returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    selin      = 1'b0;
    cmdin      = CMD_IDLE;
    lenin      = 2'b00;
    addrdatain = '0;
  endtask

  // Write beats base, base+1, ... starting at addr; no stalls.
  task automatic write_burst(input logic [31:0] addr, input logic [1:0] len,
                             input logic [31:0] base);
    int beats;
    beats      = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : (len == 2'b10) ? 4 : 8;
    selin      = 1'b1;
    cmdin      = CMD_WRITE;
    lenin      = len;
    addrdatain = addr;
    step();
    total++;
    if (ackout !== 1'b1) begin
      bad++;
      $display("FAIL wr_ack addr=%h ackout=%b expected 1", addr, ackout);
    end
    for (int i = 0; i < beats; i++) begin
      cmdin      = CMD_WDATA;
      addrdatain = base + 32'(i);
      step();
    end
    idle_in();
  endtask

  // Issue a read and collect up to 8 beats over a fixed cycle window.
  task automatic read_collect(input logic [31:0] addr, input logic [1:0] len,
                              output word_arr_t d, output len_arr_t l,
                              output int nb, output logic lat_ok,
                              output logic acked);
    selin      = 1'b1;
    cmdin      = CMD_READ;
    lenin      = len;
    addrdatain = addr;
    step();
    acked  = ackout;
    idle_in();
    nb     = 0;
    lat_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d[k] = '0;
      l[k] = '0;
    end
    for (int i = 1; i <= 14; i++) begin
      step();
      if (cmdout == CMD_RDATA) begin
        if (nb < 8) begin
          d[nb] = addrdataout;
          l[nb] = lenout;
          if (i != RD_LAT + nb) lat_ok = 1'b0;
        end
        nb++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    repeat (2) step();
    total++;
    if ({ackout, busy, cmdout, lenout, addrdataout} !== '0) begin
      bad++;
      $display("FAIL reset_outputs ack=%b busy=%b cmd=%b len=%b data=%h expected all 0",
               ackout, busy, cmdout, lenout, addrdataout);
    end
    reset = 1'b0;
    step();
    // Start an 8-beat read, then hit reset in the middle of the ack cycle.
    selin      = 1'b1;
    cmdin      = CMD_READ;
    lenin      = 2'b11;
    addrdatain = '0;
    step();
    idle_in();
    total++;
    if ({ackout, busy} !== 2'b11) begin
      bad++;
      $display("FAIL reset_pre_ack ack=%b busy=%b expected 1 1", ackout, busy);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ackout, busy, cmdout, lenout, addrdataout} !== '0) begin
      bad++;
      $display("FAIL reset_async ack=%b busy=%b cmd=%b len=%b data=%h expected all 0",
               ackout, busy, cmdout, lenout, addrdataout);
    end
    step();
    reset = 1'b0;
    repeat (3) step();
    total++;
    if ({busy, cmdout} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_release busy=%b cmd=%b expected 0 000", busy, cmdout);
    end
  endtask

  task automatic test_single_rw();
    selin      = 1'b1;
    cmdin      = CMD_WRITE;
    lenin      = 2'b00;
    addrdatain = 32'h0000_0010;
    step();
    total++;
    if ({ackout, busy} !== 2'b11) begin
      bad++;
      $display("FAIL single_wr_ack ack=%b busy=%b expected 1 1", ackout, busy);
    end
    cmdin      = CMD_WDATA;
    addrdatain = 32'hDEAD_BEEF;
    step();
    idle_in();
    total++;
    if ({ackout, busy} !== 2'b00) begin
      bad++;
      $display("FAIL single_wr_done ack=%b busy=%b expected 0 0", ackout, busy);
    end
    selin      = 1'b1;
    cmdin      = CMD_READ;
    lenin      = 2'b00;
    addrdatain = 32'h0000_0010;
    step();
    idle_in();
    total++;
    if ({ackout, busy} !== 2'b11) begin
      bad++;
      $display("FAIL single_rd_ack ack=%b busy=%b expected 1 1", ackout, busy);
    end
    step();
    total++;
    if ({ackout, cmdout} !== 4'b0000) begin
      bad++;
      $display("FAIL single_rd_early ack=%b cmd=%b expected 0 000", ackout, cmdout);
    end
    step();
    total++;
    if (cmdout !== CMD_RDATA || addrdataout !== 32'hDEAD_BEEF || lenout !== 2'b00) begin
      bad++;
      $display("FAIL single_rd_beat cmd=%b data=%h len=%b expected 101 deadbeef 00",
               cmdout, addrdataout, lenout);
    end
    step();
    total++;
    if ({busy, cmdout, lenout, addrdataout} !== '0) begin
      bad++;
      $display("FAIL single_rd_after busy=%b cmd=%b len=%b data=%h expected all 0",
               busy, cmdout, lenout, addrdataout);
    end
  endtask

  task automatic test_burst_wrap();
    word_arr_t d;
    len_arr_t  l;
    int        nb;
    logic      lat_ok;
    logic      acked;
    logic [31:0] exp_d [8];
    exp_d = '{32'd1, 32'd2, 32'd3, 32'd4, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    write_burst(32'h0000_0008, 2'b10, 32'hA2);        // indices 2..5
    write_burst(32'((DEPTH - 2) * 4), 2'b10, 32'd1);  // indices DEPTH-2..1
    read_collect(32'((DEPTH - 2) * 4), 2'b11, d, l, nb, lat_ok, acked);
    total++;
    if (acked !== 1'b1 || nb != 8 || lat_ok !== 1'b1) begin
      bad++;
      $display("FAIL wrap_shape ack=%b beats=%0d timing_ok=%b expected 1 8 1", acked, nb, lat_ok);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (d[k] !== exp_d[k] || l[k] !== 2'b11) begin
        bad++;
        $display("FAIL wrap_beat%0d data=%h len=%b expected %h 11", k, d[k], l[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_write_stall();
    word_arr_t d;
    len_arr_t  l;
    int        nb;
    logic      lat_ok;
    logic      acked;
    selin      = 1'b1;
    cmdin      = CMD_WRITE;
    lenin      = 2'b01;
    addrdatain = 32'h0000_0040;
    step();
    cmdin      = CMD_WDATA;
    addrdatain = 32'h5A5A_0001;
    step();
    idle_in();
    step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_busy1 busy=%b expected 1", busy);
    end
    step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_busy2 busy=%b expected 1", busy);
    end
    selin      = 1'b1;
    cmdin      = CMD_WDATA;
    addrdatain = 32'h5A5A_0002;
    step();
    idle_in();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_done busy=%b expected 0", busy);
    end
    read_collect(32'h0000_0040, 2'b01, d, l, nb, lat_ok, acked);
    total++;
    if (nb != 2 || d[0] !== 32'h5A5A_0001 || d[1] !== 32'h5A5A_0002 || l[0] !== 2'b01) begin
      bad++;
      $display("FAIL stall_readback beats=%0d d0=%h d1=%h len=%b expected 2 5a5a0001 5a5a0002 01",
               nb, d[0], d[1], l[0]);
    end
  endtask

  task automatic test_busy_reject();
    int extra_acks = 0;
    int beats      = 0;
    selin      = 1'b1;
    cmdin      = CMD_READ;
    lenin      = 2'b11;
    addrdatain = 32'((DEPTH - 2) * 4);
    step();                              // edge N: first read accepted
    addrdatain = 32'h0000_0010;          // second read (index 4) held from now on
    lenin      = 2'b00;
    for (int i = 1; i < RD_LAT + 8; i++) begin
      step();
      if (ackout === 1'b1) extra_acks++;
      if (cmdout == CMD_RDATA) beats++;
    end
    total++;
    if (extra_acks != 0 || beats != 8) begin
      bad++;
      $display("FAIL busy_reject acks=%0d beats=%0d expected 0 8", extra_acks, beats);
    end
    step();                              // edge N+RD_LAT+8
    idle_in();
    total++;
    if ({ackout, busy} !== 2'b11) begin
      bad++;
      $display("FAIL busy_accept ack=%b busy=%b expected 1 1", ackout, busy);
    end
    repeat (RD_LAT) step();
    total++;
    if (cmdout !== CMD_RDATA || addrdataout !== 32'hA4 || lenout !== 2'b00) begin
      bad++;
      $display("FAIL busy_second_read cmd=%b data=%h len=%b expected 101 000000a4 00",
               cmdout, addrdataout, lenout);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    word_arr_t d;
    len_arr_t  l;
    int        nb;
    logic      lat_ok;
    logic      acked;
    write_burst(32'h0000_0080, 2'b10, 32'hB0);        // indices 32..35 = B0..B3
    selin      = 1'b1;
    cmdin      = CMD_WRITE;
    lenin      = 2'b10;
    addrdatain = 32'h0000_0080;
    step();
    cmdin      = CMD_WDATA;
    addrdatain = 32'hC0;
    step();
    addrdatain = 32'hC1;
    step();
    idle_in();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ackout, busy, cmdout, lenout, addrdataout} !== '0) begin
      bad++;
      $display("FAIL midburst_reset ack=%b busy=%b cmd=%b expected 0 0 000", ackout, busy, cmdout);
    end
    step();
    reset = 1'b0;
    step();
    // A stray WDATA must not be taken as a continuation of the dead burst.
    selin      = 1'b1;
    cmdin      = CMD_WDATA;
    addrdatain = 32'hEE;
    step();
    idle_in();
    total++;
    if ({ackout, busy, cmdout} !== 5'b00000) begin
      bad++;
      $display("FAIL midburst_idle ack=%b busy=%b cmd=%b expected 0 0 000", ackout, busy, cmdout);
    end
    read_collect(32'h0000_0080, 2'b10, d, l, nb, lat_ok, acked);
    total++;
    if (nb != 4 || d[0] !== 32'hC0 || d[1] !== 32'hC1 || d[2] !== 32'hB2 || d[3] !== 32'hB3) begin
      bad++;
      $display("FAIL midburst_contents beats=%0d d=%h %h %h %h expected 4 c0 c1 b2 b3",
               nb, d[0], d[1], d[2], d[3]);
    end
  endtask

  initial begin
    test_reset();
    test_single_rw();
    test_burst_wrap();
    test_write_stall();
    test_busy_reject();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
